// File: rtl/load_store_unit.sv
// Memory-access stage: runs one word load/store on a valid/ready data bus, then pulses a response.
// Build option: define LSU_TIMEOUT_EN to abort bus transactions that exceed TIMEOUT_CYCLES.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state, state_nxt;
  logic        r_we;
  logic [29:0] r_word;
  logic [31:0] r_wdata;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misaligned;
  logic        timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be in 1..255");
  end

  assign accept     = (state == IDLE) && req_valid;
  assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;

  // mem_ready in the limit cycle still completes normally
  assign timeout = (state == BUS) && !mem_ready && (cnt == TLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (accept) begin
      cnt <= 8'd0;
    end else if (state == BUS && !mem_ready) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misaligned ? DONE : BUS;
      BUS:     if (mem_ready || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    mem_valid  = (state == BUS);
    resp_valid = (state == DONE);
    resp_err   = (state == DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_word  <= 30'd0;
      r_wdata <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_word  <= req_addr[31:2];
        r_wdata <= req_wdata;
        err_q   <= misaligned;
      end
      if (state == BUS) begin
        if (mem_ready && !r_we) rdata_q <= mem_rdata;
        if (timeout)            err_q   <= 1'b1;
      end
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = {r_word, 2'b00};
  assign mem_wdata  = r_wdata;
  assign resp_rdata = rdata_q;

endmodule
